// File: rtl/lifo_stack.sv
// Parameterised LIFO stack with registered pop data, a combinational top-of-stack peek and status flags.
// Define LIFO_STACK_ERR_FLAGS_EN to enable the sticky overflow/underflow flags (cleared by err_clr).
module lifo_stack #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDRESS_WIDTH   = 4,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     err_clr,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic [DATA_WIDTH-1:0]    top,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] AF_TH      = (ADDRESS_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDRESS_WIDTH:0] AE_TH      = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH:0]   top_ptr;
    logic [ADDRESS_WIDTH-1:0] top_idx;
    logic [ADDRESS_WIDTH-1:0] wr_idx;
    logic [ADDRESS_WIDTH:0]   count_next;
    logic                     push_ok;
    logic                     pop_ok;

    assign stack_full   = (count == FULL_COUNT);
    assign stack_empty  = (count == '0);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    assign top_ptr = count - 1'b1;
    assign top_idx = top_ptr[ADDRESS_WIDTH-1:0];
    assign top     = stack_empty ? '0 : mem[top_idx];

    // A push is still legal at full when paired with a pop: it becomes an exchange of the top entry.
    assign pop_ok  = pop && !stack_empty;
    assign push_ok = push && (!stack_full || pop_ok);
    assign wr_idx  = pop_ok ? top_idx : count[ADDRESS_WIDTH-1:0];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            count      <= count_next;
            data_valid <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[top_idx];
            end
        end
    end

    // Storage is deliberately not reset; a write during reset is suppressed so reset discards the push.
    always_ff @(posedge clk) begin
        if (push_ok && reset_n) begin
            mem[wr_idx] <= data_in;
        end
    end

`ifdef LIFO_STACK_ERR_FLAGS_EN
    // A new error wins over err_clr in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed, table-driven bench for lifo_stack plus hand-written fill, exchange and reset sequences.
module tb_lifo_stack;

`ifdef LIFO_STACK_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic [7:0] top;
    logic [4:0] count;
    logic       stack_full;
    logic       stack_empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       clr;
        int         cnt;
        logic [7:0] top;
        logic       vld;
        logic [7:0] dout;
        logic       uf;
    } vec_t;

    vec_t vecs[$];

    lifo_stack dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .top          (top),
        .count        (count),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic pu, logic po, logic [7:0] d, logic c,
                                int n, logic [7:0] t, logic v, logic [7:0] o, logic u);
        vec_t r;
        r.push = pu; r.pop = po; r.din = d; r.clr = c;
        r.cnt = n; r.top = t; r.vld = v; r.dout = o; r.uf = u;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkFlags(input string tag, input int n);
        checkOutput({tag, " count"}, int'(count), n);
        checkOutput({tag, " empty"}, int'(stack_empty), int'(n == 0));
        checkOutput({tag, " full"}, int'(stack_full), int'(n == 16));
        checkOutput({tag, " almost_full"}, int'(almost_full), int'(n >= 14));
        checkOutput({tag, " almost_empty"}, int'(almost_empty), int'(n <= 2));
    endtask

    // Called at a falling edge: drive for one rising edge, return to idle, land on the next falling edge.
    task automatic applyStimulus(input logic pu, input logic po, input logic [7:0] d, input logic c);
        push = pu; pop = po; data_in = d; err_clr = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; data_in = 8'h00; err_clr = 1'b0;
        reset_n = 1'b0;

        // empty stack: push/pop LIFO order, underflow, exchange, push+pop on empty
        vecs.push_back(mk(1, 0, 8'h11, 0, 1, 8'h11, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 8'h22, 0, 2, 8'h22, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 8'h33, 0, 3, 8'h33, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 2, 8'h22, 1, 8'h33, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 8'h11, 1, 8'h22, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h11, 0, 8'h22, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 8'h11, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 8'h11, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h11, 0));
        vecs.push_back(mk(1, 0, 8'h55, 0, 1, 8'h55, 0, 8'h11, 0));
        vecs.push_back(mk(1, 1, 8'h66, 0, 1, 8'h66, 1, 8'h55, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 8'h66, 0));
        vecs.push_back(mk(1, 1, 8'h77, 0, 1, 8'h77, 0, 8'h66, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'h77, 0, 8'h66, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 8'h77, 0));

        #12;
        checkFlags("reset", 0);
        checkOutput("reset data_out", int'(data_out), 0);
        checkOutput("reset data_valid", int'(data_valid), 0);
        checkOutput("reset top", int'(top), 0);
        checkOutput("reset overflow", int'(overflow), 0);
        checkOutput("reset underflow", int'(underflow), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
            checkFlags(tag, vecs[i].cnt);
            checkOutput({tag, " top"}, int'(top), int'(vecs[i].top));
            checkOutput({tag, " data_valid"}, int'(data_valid), int'(vecs[i].vld));
            checkOutput({tag, " data_out"}, int'(data_out), int'(vecs[i].dout));
            checkOutput({tag, " underflow"}, int'(underflow), int'(ERR_EN & vecs[i].uf));
            checkOutput({tag, " overflow"}, int'(overflow), 0);
        end

        // fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
            checkFlags($sformatf("fill%0d", i), i + 1);
            checkOutput($sformatf("fill%0d top", i), int'(top), i);
        end
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
        checkFlags("ovf", 16);
        checkOutput("ovf top", int'(top), 8'h0F);
        checkOutput("ovf overflow", int'(overflow), int'(ERR_EN));
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b1);
        checkOutput("ovf clr+err overflow", int'(overflow), int'(ERR_EN));
        checkOutput("ovf clr+err top", int'(top), 8'h0F);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ovf cleared", int'(overflow), 0);

        // exchange while full
        applyStimulus(1'b1, 1'b1, 8'hBB, 1'b0);
        checkFlags("xchg full", 16);
        checkOutput("xchg full top", int'(top), 8'hBB);
        checkOutput("xchg full data_out", int'(data_out), 8'h0F);
        checkOutput("xchg full data_valid", int'(data_valid), 1);
        checkOutput("xchg full overflow", int'(overflow), 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop after xchg", int'(data_out), 8'hBB);
        checkOutput("pop after xchg top", int'(top), 8'h0E);

        // async reset between clock edges, after 5 pushes and a pop
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        checkFlags("five", 5);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("five pop data_out", int'(data_out), 8'hC4);
        checkOutput("five pop data_valid", int'(data_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkFlags("async", 0);
        checkOutput("async data_valid", int'(data_valid), 0);
        checkOutput("async data_out", int'(data_out), 0);
        checkOutput("async top", int'(top), 0);

        // push held during reset is discarded
        push = 1'b1; data_in = 8'hEE;
        @(posedge clk);
        #1;
        checkFlags("rst push", 0);
        push = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkFlags("post rst", 0);
        checkOutput("post rst top", int'(top), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 Parameter DATA_WIDTH, 8, bit width of each stack entry.
REQ-002 Parameter ADDRESS_WIDTH, 4, depth = 2**ADDRESS_WIDTH entries.
REQ-003 Parameter ALMOST_FULL_TH, 14, count at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_TH, 2, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 push  input  1  write data_in onto top of stack.
REQ-008 pop  input  1  remove top entry and present it on data_out.
REQ-009 data_in  input  DATA_WIDTH  push data.
REQ-010 err_clr  input  1  clears sticky error flags.
REQ-011 data_out  output  DATA_WIDTH  registered popped data.
REQ-012 data_valid  output  1  one-cycle pulse, data_out updated by accepted pop.
REQ-013 top  output  DATA_WIDTH  combinational peek of current top entry; 0 when empty.
REQ-014 count  output  ADDRESS_WIDTH+1  number of stored entries, 0..2**ADDRESS_WIDTH.
REQ-015 stack_full, stack_empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Status flags SHALL be decoded from registered count: full = (count == 2**ADDRESS_WIDTH), empty = (count == 0), almost_full = (count >= ALMOST_FULL_TH), almost_empty = (count <= ALMOST_EMPTY_TH).
REQ-018 Push only, not full: mem[count] <= data_in, count <= count+1, visible next cycle.
REQ-019 Pop only, not empty: data_out <= mem[count-1], data_valid = 1 next cycle, count <= count-1.
REQ-020 Push and pop, not empty: exchange -- data_out <= old top, mem[count-1] <= data_in, count unchanged, data_valid = 1; permitted when full.
REQ-021 Push and pop, empty: push performed (count 0->1), pop rejected, data_valid = 0.
REQ-022 Push only while full: rejected, memory and count unchanged.
REQ-023 Pop while empty: rejected, data_out holds previous value, data_valid = 0.
REQ-024 data_out SHALL hold its value between accepted pops; data_valid SHALL be 0 in any cycle not following an accepted pop.
REQ-025 Count arithmetic SHALL never wrap: count stays within 0..2**ADDRESS_WIDTH under any input sequence.
REQ-026 Latency: pop to data_out/data_valid 1 cycle; push to top 1 cycle.

Reset
REQ-027 On reset_n low, asynchronously: count = 0, data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
REQ-028 Resulting flags: stack_empty = 1, stack_full = 0, almost_empty = 1, almost_full = 0, top = 0.
REQ-029 Memory contents SHALL NOT be reset and are unreadable until written (top forced 0 when empty).
REQ-030 Reset asserted mid-operation SHALL discard any push/pop in that cycle.

Configuration
REQ-031 Macro LIFO_STACK_ERR_FLAGS_EN defined: overflow sets on rejected push (REQ-022), underflow sets on rejected pop (REQ-021, REQ-023); both hold until err_clr = 1 for one cycle; err_clr and a new error in the same cycle leave the flag set.
REQ-032 Macro undefined: overflow and underflow tied 0, err_clr ignored, ports retained.

Verification
REQ-033 Reset, then push 0x11,0x22,0x33 -> count = 3, top = 0x33; three pops -> data_out 0x33,0x22,0x11 each with data_valid pulse, stack_empty = 1 after final pop.
REQ-034 Push 16 values 0x00..0x0F -> stack_full = 1 and almost_full = 1 from count 14; 17th push 0xAA -> count stays 16, top = 0x0F, overflow = 1 (macro on) / 0 (macro off).
REQ-035 Empty stack, pop -> data_valid = 0, data_out unchanged, underflow = 1 (macro on); err_clr pulse -> underflow = 0.
REQ-036 Stack holding 0x55, push 0x66 with pop same cycle -> data_out = 0x55, data_valid = 1, count = 1, top = 0x66; repeat when full -> count stays 16.
REQ-037 Empty stack, push 0x77 with pop same cycle -> count = 1, top = 0x77, data_valid = 0.
REQ-038 Push 5 entries, assert reset_n low between clock edges -> count = 0, stack_empty = 1, data_valid = 0 immediately, before next clk edge.
